// File: rtl/dfe_cfg_pkg.sv
// Shared types and constants for the DFE coefficient/configuration controller.
// Optional stall timeout in the controller is enabled with DFE_CFG_TIMEOUT_EN.
package dfe_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_GAP = 2'd2,
        ST_COMMIT   = 2'd3
    } cfg_state_e;

    typedef enum logic [1:0] {
        TGT_FRAC_DEC  = 2'd0,
        TGT_NOTCH_1M  = 2'd1,
        TGT_NOTCH_2M4 = 2'd2,
        TGT_CTRL      = 2'd3
    } cfg_target_e;

    // Control-word bit positions
    localparam int unsigned CW_FRAC_DEC_BYP = 0;
    localparam int unsigned CW_IIR_1M_BYP   = 1;
    localparam int unsigned CW_IIR_2M4_BYP  = 2;
    localparam int unsigned CW_CIC_BYP      = 3;
    localparam int unsigned CW_DEC_LSB      = 4;
    localparam int unsigned CW_DEC_MSB      = 8;
    localparam int unsigned CW_DEC_W        = CW_DEC_MSB - CW_DEC_LSB + 1;

    localparam logic        RST_BYPASS     = 1'b1;
    localparam int unsigned RST_DEC_FACTOR = 1;

    // A decimation factor is usable only in the range 1..max_f
    function automatic logic dec_factor_ok(input logic [CW_DEC_W-1:0] f,
                                           input int unsigned         max_f);
        return (f != '0) && (32'(f) <= max_f);
    endfunction

endpackage

// File: rtl/dfe_cfg_shadow_bank.sv
// Write-indexed shadow register array; contents are continuously visible on bank.
module dfe_cfg_shadow_bank
    import dfe_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 20,
    parameter int unsigned IDX_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [DEPTH-1:0][WIDTH-1:0]  bank
);

    logic [DEPTH-1:0][WIDTH-1:0] bank_q;
    logic [DEPTH-1:0][WIDTH-1:0] bank_d;

    // Out-of-range indices match no entry and are dropped
    always_comb begin
        bank_d = bank_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                bank_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank = bank_q;

endmodule

// File: rtl/dfe_cfg_ctrl.sv
// Host-side burst loader for DFE filter coefficients and control word; commits in a sample gap.
// Define DFE_CFG_TIMEOUT_EN to abort bursts that stall in LOAD for TIMEOUT_CYC cycles.
module dfe_cfg_ctrl
    import dfe_cfg_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH    = 20,
    parameter int unsigned N_TAP          = 146,
    parameter int unsigned COEFF_DEPTH    = 5,
    parameter int unsigned MAX_DEC_FACTOR = 16,
    parameter int unsigned DEC_WIDTH      = $clog2(MAX_DEC_FACTOR),
    parameter int unsigned TIMEOUT_CYC    = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [1:0]                              cfg_target,
    input  logic [COEFF_WIDTH-1:0]                  cfg_data,
    input  logic                                    cfg_last,
    input  logic                                    sample_valid_in,
    output logic                                    frac_dec_coeff_wr_en,
    output logic [N_TAP-1:0][COEFF_WIDTH-1:0]       frac_dec_coeff_data,
    output logic                                    iir_coeff_wr_en_1MHz,
    output logic                                    iir_coeff_wr_en_2_4MHz,
    output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] iir_coeff_1MHz,
    output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] iir_coeff_2_4MHz,
    output logic                                    frac_dec_bypass,
    output logic                                    iir_bypass_1MHz,
    output logic                                    iir_bypass_2_4MHz,
    output logic                                    cic_bypass,
    output logic [DEC_WIDTH:0]                      cic_dec_factor,
    output logic                                    busy,
    output logic                                    cfg_done,
    output logic                                    cfg_error
);

    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] LOAD     = ST_LOAD;
    localparam logic [1:0] WAIT_GAP = ST_WAIT_GAP;
    localparam logic [1:0] COMMIT   = ST_COMMIT;

    localparam int unsigned MAX_LEN = (N_TAP > COEFF_DEPTH) ? N_TAP : COEFF_DEPTH;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned DF_W    = DEC_WIDTH + 1;
    localparam int unsigned CTRL_W  = CW_DEC_MSB + 1;

    localparam logic [CNT_W-1:0] LEN_FRAC  = CNT_W'(N_TAP);
    localparam logic [CNT_W-1:0] LEN_NOTCH = CNT_W'(COEFF_DEPTH);
    localparam logic [CNT_W-1:0] LEN_CTRL  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        tgt_q, tgt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              cfg_done_q, cfg_done_d;
    logic              cfg_error_q, cfg_error_d;
    logic              fd_wr_q, fd_wr_d;
    logic              n1_wr_q, n1_wr_d;
    logic              n2_wr_q, n2_wr_d;
    logic              fd_byp_q, fd_byp_d;
    logic              n1_byp_q, n1_byp_d;
    logic              n2_byp_q, n2_byp_d;
    logic              cic_byp_q, cic_byp_d;
    logic [DF_W-1:0]   dec_q, dec_d;

`ifdef DFE_CFG_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    logic              xfer_c;
    logic [1:0]        cur_tgt_c;
    logic [CNT_W-1:0]  cur_cnt_c;
    logic [CNT_W-1:0]  exp_len_c;
    logic [CNT_W-1:0]  next_cnt_c;
    logic              overflow_c;
    logic              word_we_c;
    logic [CTRL_W-1:0] ctrl_in_c;
    logic              ctrl_ok_c;
    logic              commit_c;

    // The first word of a burst takes its target straight from the port
    always_comb begin
        xfer_c     = cfg_valid && cfg_ready_q;
        cur_tgt_c  = (state_q == IDLE) ? cfg_target : tgt_q;
        cur_cnt_c  = (state_q == IDLE) ? '0 : count_q;
        case (cur_tgt_c)
            TGT_FRAC_DEC:                exp_len_c = LEN_FRAC;
            TGT_NOTCH_1M, TGT_NOTCH_2M4: exp_len_c = LEN_NOTCH;
            default:                     exp_len_c = LEN_CTRL;
        endcase
        next_cnt_c = cur_cnt_c + CNT_W'(1);
        overflow_c = cur_cnt_c >= exp_len_c;
        word_we_c  = xfer_c && !overflow_c;
        ctrl_in_c  = cfg_data[CW_DEC_MSB:0];
        ctrl_ok_c  = dec_factor_ok(ctrl_in_c[CW_DEC_MSB:CW_DEC_LSB], MAX_DEC_FACTOR);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tgt_d       = tgt_q;
        ctrl_d      = ctrl_q;
        cfg_error_d = 1'b0;
`ifdef DFE_CFG_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            IDLE, LOAD: begin
                if (xfer_c) begin
`ifdef DFE_CFG_TIMEOUT_EN
                    timer_d = '0;
`endif
                    tgt_d = cur_tgt_c;
                    if (overflow_c) begin
                        state_d     = IDLE;
                        count_d     = '0;
                        cfg_error_d = 1'b1;
                    end else begin
                        count_d = next_cnt_c;
                        if (cur_tgt_c == TGT_CTRL) begin
                            ctrl_d = ctrl_in_c;
                        end
                        if (!cfg_last) begin
                            state_d = LOAD;
                        end else if ((next_cnt_c == exp_len_c) &&
                                     ((cur_tgt_c != TGT_CTRL) || ctrl_ok_c)) begin
                            state_d = WAIT_GAP;
                        end else begin
                            state_d     = IDLE;
                            count_d     = '0;
                            cfg_error_d = 1'b1;
                        end
                    end
                end
`ifdef DFE_CFG_TIMEOUT_EN
                else if (state_q == LOAD) begin
                    if (timer_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
                        state_d     = IDLE;
                        count_d     = '0;
                        cfg_error_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
`endif
            end
            WAIT_GAP: begin
                if (!sample_valid_in) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // Commit-cycle outputs are registered on entry so they coincide with COMMIT
        commit_c    = (state_d == COMMIT);
        cfg_done_d  = commit_c;
        fd_wr_d     = commit_c && (tgt_d == TGT_FRAC_DEC);
        n1_wr_d     = commit_c && (tgt_d == TGT_NOTCH_1M);
        n2_wr_d     = commit_c && (tgt_d == TGT_NOTCH_2M4);
        cfg_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d      = (state_d != IDLE);

        fd_byp_d  = fd_byp_q;
        n1_byp_d  = n1_byp_q;
        n2_byp_d  = n2_byp_q;
        cic_byp_d = cic_byp_q;
        dec_d     = dec_q;
        if (commit_c && (tgt_d == TGT_CTRL)) begin
            fd_byp_d  = ctrl_d[CW_FRAC_DEC_BYP];
            n1_byp_d  = ctrl_d[CW_IIR_1M_BYP];
            n2_byp_d  = ctrl_d[CW_IIR_2M4_BYP];
            cic_byp_d = ctrl_d[CW_CIC_BYP];
            dec_d     = DF_W'(ctrl_d[CW_DEC_MSB:CW_DEC_LSB]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            tgt_q       <= '0;
            ctrl_q      <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
            fd_wr_q     <= 1'b0;
            n1_wr_q     <= 1'b0;
            n2_wr_q     <= 1'b0;
            fd_byp_q    <= RST_BYPASS;
            n1_byp_q    <= RST_BYPASS;
            n2_byp_q    <= RST_BYPASS;
            cic_byp_q   <= RST_BYPASS;
            dec_q       <= DF_W'(RST_DEC_FACTOR);
`ifdef DFE_CFG_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tgt_q       <= tgt_d;
            ctrl_q      <= ctrl_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            cfg_error_q <= cfg_error_d;
            fd_wr_q     <= fd_wr_d;
            n1_wr_q     <= n1_wr_d;
            n2_wr_q     <= n2_wr_d;
            fd_byp_q    <= fd_byp_d;
            n1_byp_q    <= n1_byp_d;
            n2_byp_q    <= n2_byp_d;
            cic_byp_q   <= cic_byp_d;
            dec_q       <= dec_d;
`ifdef DFE_CFG_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    dfe_cfg_shadow_bank #(
        .DEPTH (N_TAP),
        .WIDTH (COEFF_WIDTH),
        .IDX_W (CNT_W)
    ) u_bank_frac_dec (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (word_we_c && (cur_tgt_c == TGT_FRAC_DEC)),
        .wr_idx  (cur_cnt_c),
        .wr_data (cfg_data),
        .bank    (frac_dec_coeff_data)
    );

    dfe_cfg_shadow_bank #(
        .DEPTH (COEFF_DEPTH),
        .WIDTH (COEFF_WIDTH),
        .IDX_W (CNT_W)
    ) u_bank_notch_1m (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (word_we_c && (cur_tgt_c == TGT_NOTCH_1M)),
        .wr_idx  (cur_cnt_c),
        .wr_data (cfg_data),
        .bank    (iir_coeff_1MHz)
    );

    dfe_cfg_shadow_bank #(
        .DEPTH (COEFF_DEPTH),
        .WIDTH (COEFF_WIDTH),
        .IDX_W (CNT_W)
    ) u_bank_notch_2m4 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (word_we_c && (cur_tgt_c == TGT_NOTCH_2M4)),
        .wr_idx  (cur_cnt_c),
        .wr_data (cfg_data),
        .bank    (iir_coeff_2_4MHz)
    );

    assign cfg_ready              = cfg_ready_q;
    assign busy                   = busy_q;
    assign cfg_done               = cfg_done_q;
    assign cfg_error              = cfg_error_q;
    assign frac_dec_coeff_wr_en   = fd_wr_q;
    assign iir_coeff_wr_en_1MHz   = n1_wr_q;
    assign iir_coeff_wr_en_2_4MHz = n2_wr_q;
    assign frac_dec_bypass        = fd_byp_q;
    assign iir_bypass_1MHz        = n1_byp_q;
    assign iir_bypass_2_4MHz      = n2_byp_q;
    assign cic_bypass             = cic_byp_q;
    assign cic_dec_factor         = dec_q;

endmodule

// File: tb/tb_dfe_cfg_ctrl.sv
// Bench for dfe_cfg_ctrl: burst-level reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_dfe_cfg_ctrl;

    localparam int CW  = 20;
    localparam int NT  = 146;
    localparam int CD  = 5;
    localparam int MDF = 16;
    localparam int DW  = 4;
    localparam int TO  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_valid = 1'b0;
    logic cfg_last = 1'b0;
    logic svi = 1'b0;
    logic [1:0] cfg_target = 2'd0;
    logic [CW-1:0] cfg_data = '0;

    logic cfg_ready, fd_wr, n1_wr, n2_wr, fd_byp, n1_byp, n2_byp, cic_byp, busy, cfg_done, cfg_error;
    logic [NT-1:0][CW-1:0] fd_data;
    logic [CD-1:0][CW-1:0] n1_data, n2_data;
    logic [DW:0] dec_factor;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dfe_cfg_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_target(cfg_target),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .sample_valid_in(svi),
        .frac_dec_coeff_wr_en(fd_wr), .frac_dec_coeff_data(fd_data),
        .iir_coeff_wr_en_1MHz(n1_wr), .iir_coeff_wr_en_2_4MHz(n2_wr),
        .iir_coeff_1MHz(n1_data), .iir_coeff_2_4MHz(n2_data),
        .frac_dec_bypass(fd_byp), .iir_bypass_1MHz(n1_byp), .iir_bypass_2_4MHz(n2_byp),
        .cic_bypass(cic_byp), .cic_dec_factor(dec_factor),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (burst level) ----------------
    logic [CW-1:0] m_fd [NT];
    logic [CW-1:0] m_n1 [CD];
    logic [CW-1:0] m_n2 [CD];
    bit m_known [3];
    int m_n, m_t, m_ctrl, m_stall;
    bit m_pend, m_commit, model_live;
    bit e_wr [3];
    bit e_done, e_err;
    bit e_byp [4];
    int e_dec;

    function automatic int exp_len(input int t);
        return (t == 0) ? NT : ((t == 3) ? 1 : CD);
    endfunction

    function automatic bit ctrl_ok(input int w);
        int d;
        d = (w >> 4) & 31;
        return (d >= 1) && (d <= MDF);
    endfunction

    task automatic model_error(input int t);
        e_err = 1; m_n = 0; m_pend = 0; m_stall = 0;
        if (t < 3) m_known[t] = 0;
    endtask

    always @(posedge clk) begin : model_blk
        bit was_pend, was_commit;
        int t;
        model_live = 1;
        was_pend = m_pend;
        was_commit = m_commit;
        e_wr[0] = 0; e_wr[1] = 0; e_wr[2] = 0; e_done = 0; e_err = 0; m_commit = 0;
        if (rst) begin
            for (int i = 0; i < NT; i++) m_fd[i] = '0;
            for (int i = 0; i < CD; i++) begin m_n1[i] = '0; m_n2[i] = '0; end
            for (int i = 0; i < 3; i++) m_known[i] = 1;
            for (int i = 0; i < 4; i++) e_byp[i] = 1;
            e_dec = 1; m_n = 0; m_t = 0; m_ctrl = 0; m_pend = 0; m_stall = 0;
        end else if (was_pend) begin
            if (!svi) begin
                m_commit = 1; m_pend = 0; e_done = 1; m_n = 0;
                if (m_t == 3) begin
                    for (int i = 0; i < 4; i++) e_byp[i] = ((m_ctrl >> i) & 1) != 0;
                    e_dec = (m_ctrl >> 4) & 31;
                end else begin
                    e_wr[m_t] = 1; m_known[m_t] = 1;
                end
            end
        end else if (!was_commit && cfg_valid) begin
            t = (m_n == 0) ? int'(cfg_target) : m_t;
            m_stall = 0;
            if (m_n >= exp_len(t)) model_error(t);
            else begin
                if (t == 0) m_fd[m_n] = cfg_data;
                else if (t == 1) m_n1[m_n] = cfg_data;
                else if (t == 2) m_n2[m_n] = cfg_data;
                else m_ctrl = int'(cfg_data);
                m_n++; m_t = t;
                if (cfg_last) begin
                    if (m_n == exp_len(t) && (t != 3 || ctrl_ok(m_ctrl))) m_pend = 1;
                    else model_error(t);
                end
            end
        end else if (m_n > 0) begin
`ifdef DFE_CFG_TIMEOUT_EN
            m_stall++;
            if (m_stall == TO) model_error(m_t);
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp_blk
        int bad;
        if (model_live) begin
            chk("cfg_ready", cfg_ready, !m_pend && !m_commit);
            chk("busy", busy, (m_n > 0) || m_pend || m_commit);
            chk("cfg_done", cfg_done, e_done);
            chk("cfg_error", cfg_error, e_err);
            chk("wr_en_frac", fd_wr, e_wr[0]);
            chk("wr_en_1MHz", n1_wr, e_wr[1]);
            chk("wr_en_2_4MHz", n2_wr, e_wr[2]);
            chk("bypass_frac", fd_byp, e_byp[0]);
            chk("bypass_1MHz", n1_byp, e_byp[1]);
            chk("bypass_2_4MHz", n2_byp, e_byp[2]);
            chk("bypass_cic", cic_byp, e_byp[3]);
            chk("cic_dec_factor", dec_factor, e_dec);
            if (m_known[0]) begin
                bad = -1;
                for (int i = 0; i < NT; i++) if (bad < 0 && fd_data[i] !== m_fd[i]) bad = i;
                n_checks++;
                if (bad < 0) n_pass++;
                else $display("FAIL frac_bank[%0d]: got %0h expected %0h at %0t", bad, fd_data[bad], m_fd[bad], $time);
            end
            if (m_known[1]) begin
                bad = -1;
                for (int i = 0; i < CD; i++) if (bad < 0 && n1_data[i] !== m_n1[i]) bad = i;
                n_checks++;
                if (bad < 0) n_pass++;
                else $display("FAIL notch1_bank[%0d]: got %0h expected %0h at %0t", bad, n1_data[bad], m_n1[bad], $time);
            end
            if (m_known[2]) begin
                bad = -1;
                for (int i = 0; i < CD; i++) if (bad < 0 && n2_data[i] !== m_n2[i]) bad = i;
                n_checks++;
                if (bad < 0) n_pass++;
                else $display("FAIL notch2_bank[%0d]: got %0h expected %0h at %0t", bad, n2_data[bad], m_n2[bad], $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_valid = 0; cfg_last = 0;
    endtask

    task automatic send_word(input int tgt, input int data, input bit last);
        bit ok;
        bit r;
        ok = 0;
        cfg_valid = 1; cfg_target = 2'(tgt); cfg_data = CW'(data); cfg_last = last;
        for (int i = 0; i < 64 && !ok; i++) begin
            r = cfg_ready;
            tick();
            if (r) ok = 1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_word: cfg_ready never high at %0t", $time);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [CD-1:0][CW-1:0] lit;
        int cnt;
        repeat (3) tick();
        rst = 0;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bypass", {fd_byp, n1_byp, n2_byp, cic_byp}, 4'b1111);
        chk("rst_dec", dec_factor, 1);
        tick();
        chk("rst_ready_after", cfg_ready, 1);

        // Target 1: words 1..5, gap immediately available
        svi = 0;
        for (int i = 1; i <= 5; i++) send_word(1, i, i == 5);
        idle_in();
        chk("t1_wr_early", n1_wr, 0);
        tick();
        lit = {20'd5, 20'd4, 20'd3, 20'd2, 20'd1};
        chk("t1_wr_pulse", n1_wr, 1);
        chk("t1_done", cfg_done, 1);
        chk("t1_coeffs", n1_data, lit);
        tick();
        chk("t1_wr_end", n1_wr, 0);

        // Target 0: full bank while samples keep flowing
        svi = 1;
        for (int i = 0; i < NT; i++) send_word(0, i * 1000 - 50000, i == NT - 1);
        idle_in();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (fd_wr) cnt++; end
        chk("t0_no_wr_while_busy", cnt, 0);
        svi = 0;
        tick();
        chk("t0_wr_pulse", fd_wr, 1);
        chk("t0_coeff0", fd_data[0], 20'hF3CB0);
        chk("t0_coeff145", fd_data[145], 20'd95000);
        tick();
        chk("t0_wr_end", fd_wr, 0);

        // Target 2: short burst is rejected
        for (int i = 0; i < 3; i++) send_word(2, 7 + i, i == 2);
        idle_in();
        chk("t2_short_err", cfg_error, 1);
        chk("t2_short_ready", cfg_ready, 1);
        chk("t2_short_no_wr", n2_wr, 0);
        tick();
        chk("t2_err_end", cfg_error, 0);

        // Control word 0x025
        send_word(3, 'h025, 1);
        idle_in();
        tick();
        chk("ctrl_done", cfg_done, 1);
        tick();
        chk("ctrl_bypass", {fd_byp, n1_byp, n2_byp, cic_byp}, 4'b1010);
        chk("ctrl_dec", dec_factor, 2);
        // Zero decimation is rejected, outputs hold
        send_word(3, 'h000, 1);
        idle_in();
        chk("ctrl_zero_err", cfg_error, 1);
        tick();
        chk("ctrl_zero_hold", {fd_byp, n1_byp, n2_byp, cic_byp}, 4'b1010);
        chk("ctrl_zero_dec", dec_factor, 2);
        // Decimation above max rejected; exactly max accepted
        send_word(3, 'h111, 1);
        idle_in();
        chk("ctrl_17_err", cfg_error, 1);
        tick();
        send_word(3, 'h100, 1);
        idle_in();
        repeat (2) tick();
        chk("ctrl_16_dec", dec_factor, 16);
        chk("ctrl_16_bypass", {fd_byp, n1_byp, n2_byp, cic_byp}, 4'b0000);
        // Two control words overflow the expected length
        send_word(3, 'h013, 0);
        send_word(3, 'h013, 1);
        idle_in();
        chk("ctrl_overflow_err", cfg_error, 1);
        tick();

        // Reset in the middle of a target-0 burst
        for (int i = 0; i < 60; i++) send_word(0, i + 3, 0);
        idle_in();
        rst = 1;
        tick();
        rst = 0;
        chk("midload_rst_bypass", {fd_byp, n1_byp, n2_byp, cic_byp}, 4'b1111);
        chk("midload_rst_dec", dec_factor, 1);
        chk("midload_rst_ready", cfg_ready, 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (fd_wr) cnt++; end
        chk("midload_rst_no_wr", cnt, 0);
        for (int i = 1; i <= 5; i++) send_word(1, i * 10, i == 5);
        idle_in();
        tick();
        lit = {20'd50, 20'd40, 20'd30, 20'd20, 20'd10};
        chk("post_rst_t1_wr", n1_wr, 1);
        chk("post_rst_t1_coeffs", n1_data, lit);
        tick();

        // Reset during the commit cycle
        for (int i = 0; i < 5; i++) send_word(2, 100 + i, i == 4);
        idle_in();
        tick();
        chk("commit_rst_pre_wr", n2_wr, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("commit_rst_wr", n2_wr, 0);
        chk("commit_rst_done", cfg_done, 0);
        tick();

        // Long stall mid-burst
        send_word(1, 11, 0);
        send_word(1, 12, 0);
        idle_in();
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin tick(); if (cfg_error) cnt++; end
`ifdef DFE_CFG_TIMEOUT_EN
        chk("stall_timeout_err", cnt, 1);
        chk("stall_timeout_idle", busy, 0);
`else
        chk("stall_no_err", cnt, 0);
        chk("stall_still_busy", busy, 1);
        for (int i = 3; i <= 5; i++) send_word(1, 10 + i, i == 5);
        idle_in();
        tick();
        chk("stall_resume_wr", n1_wr, 1);
`endif
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
